// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//
// Shared definitions for the instruction-fetch stage.
//   regval_t         : 32-bit machine word (addresses, instructions, PCs)
//   fetch_state_t    : fetch FSM state code, with FETCH / DISCARD / STALL
//                      provided as plain localparam constants
//   fetch_entry_t    : {instruction, pc} pair, as held by the output slot
//                      and by the skid buffer
//   DEFAULT_RESET_PC : fetch address used after reset unless overridden
//   advance_pc()     : sequential PC step, wrapping modulo 2^32
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef logic [31:0] regval_t;

    typedef logic [1:0] fetch_state_t;

    // FETCH   : a request for fetch_pc is on the memory port
    // DISCARD : the memory port still carries a request that a redirect made
    //           stale; its data will be thrown away when it arrives
    // STALL   : both the output slot and the skid are full, so no request
    localparam fetch_state_t FETCH   = 2'd0;
    localparam fetch_state_t DISCARD = 2'd1;
    localparam fetch_state_t STALL   = 2'd2;

    localparam regval_t DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        regval_t instruction;
        regval_t pc;
    } fetch_entry_t;

    // Plain 32-bit addition: the carry out of bit 31 is dropped on purpose,
    // so 32'hFFFF_FFFC steps to 32'h0000_0000 with no overflow indication.
    function automatic regval_t advance_pc(input regval_t pc, input regval_t step);
        return pc + step;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// ---------------------------------------------------------------------------
// fetch_skid_buffer
//
// One-entry holding register for a fetched {instruction, pc} pair that came
// back from memory while the downstream output slot was still occupied and
// stalled.
//
// Ports:
//   clock      in   pipeline clock
//   reset_n    in   synchronous active-low reset (empties the buffer)
//   load       in   capture load_entry and mark the buffer full
//   drain      in   the held entry has been moved out; mark the buffer empty
//   clear      in   throw the held entry away (redirect); wins over load
//   load_entry in   {instruction, pc} to capture
//   full       out  buffer holds a valid entry
//   entry      out  the held {instruction, pc}
// ---------------------------------------------------------------------------
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic         drain,
    input  logic         clear,
    input  fetch_entry_t load_entry,
    output logic         full,
    output fetch_entry_t entry
);

    // The buffer is a single register plus a full flag. A clear from a
    // redirect must win over a simultaneous load so that a word arriving in
    // the same cycle as a redirect can never survive into the new stream.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            full  <= 1'b0;
            entry <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            entry <= load_entry;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch.sv
// ---------------------------------------------------------------------------
// fetch
//
// Instruction-fetch stage at the head of the pipeline. Issues one
// instruction-memory request at a time, presents each returned word with its
// PC in an output slot, and parks one extra word in a skid buffer when the
// downstream stage is holding. PC redirects from the write stage abandon any
// in-flight request (its data is dropped when it finally arrives) and are
// acknowledged with a one-cycle has_flushed pulse.
//
// Parameters:
//   RESET_PC      fetch address after reset
//   PC_INCREMENT  added to fetch_pc for every accepted instruction
//
// Ports:
//   clock            in   pipeline clock
//   reset_n          in   synchronous active-low reset
//   address_enable   out  memory request, held high until data_valid
//   address          out  memory word address for the current request
//   data             in   instruction word returned by memory
//   data_valid       in   memory completes the current request this cycle
//   redirect         in   write stage loads the PC this cycle
//   redirect_pc      in   new PC when redirect is high
//   hold             in   downstream does not consume the slot this cycle
//   out_valid        out  out_instruction / out_pc are valid
//   out_instruction  out  fetched instruction
//   out_pc           out  PC of out_instruction
//   next_pc          out  current fetch_pc, to the write stage
//   has_flushed      out  high the cycle after any redirect
// ---------------------------------------------------------------------------
module fetch
    import fetch_pkg::*;
#(
    parameter regval_t     RESET_PC     = DEFAULT_RESET_PC,
    parameter int unsigned PC_INCREMENT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        address_enable,
    output logic [31:0] address,
    input  logic [31:0] data,
    input  logic        data_valid,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        hold,
    output logic        out_valid,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic [31:0] next_pc,
    output logic        has_flushed
);

    localparam regval_t PC_STEP = regval_t'(PC_INCREMENT);

    fetch_state_t state;
    regval_t      fetch_pc;
    regval_t      discard_addr;

    logic         slot_consumed;
    logic         slot_free;

    logic         skid_load;
    logic         skid_drain;
    logic         skid_clear;
    logic         skid_full;
    fetch_entry_t skid_load_entry;
    fetch_entry_t skid_entry;

    // The slot is consumed whenever it is valid and downstream is not
    // holding; it is free for a new word when it is empty or being consumed.
    assign slot_consumed = out_valid & ~hold;
    assign slot_free     = ~out_valid | ~hold;

    // The request is a level that only drops while the skid is full. It is
    // gated with reset_n so that nothing is requested while reset is held,
    // even before the first reset edge has cleared the state register. In
    // DISCARD the stale address is kept on the bus until memory finishes it.
    assign address_enable = reset_n & (state != STALL);
    assign address        = (state == DISCARD) ? discard_addr : fetch_pc;

    // next_pc comes straight from the fetch_pc register, so a redirect only
    // becomes visible here one cycle later.
    assign next_pc = fetch_pc;

    assign skid_load_entry = '{instruction: data, pc: fetch_pc};

    // Skid control. A word is parked only when it arrives in FETCH while the
    // slot is occupied and held. The parked word leaves as soon as
    // downstream stops holding. A redirect empties it unconditionally.
    always_comb begin
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;
        if (redirect) begin
            skid_clear = 1'b1;
        end else begin
            case (state)
                FETCH:   skid_load  = data_valid & out_valid & hold;
                STALL:   skid_drain = ~hold;
                default: ;
            endcase
        end
    end

    fetch_skid_buffer u_skid (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (skid_load),
        .drain      (skid_drain),
        .clear      (skid_clear),
        .load_entry (skid_load_entry),
        .full       (skid_full),
        .entry      (skid_entry)
    );

    // Main fetch FSM, PC register and output slot.
    //
    // A redirect is handled first and overrides data_valid and hold in every
    // state: the slot is invalidated, fetch_pc takes redirect_pc, and the
    // only question left is whether a memory request is still in flight.
    // If it is (FETCH without data_valid, or DISCARD without data_valid) we
    // must keep presenting the old address until memory completes it, which
    // is what DISCARD does. A redirect in DISCARD leaves discard_addr alone
    // because the bus request it describes has not changed.
    //
    // Without a redirect, a consumed slot is cleared first and may then be
    // reloaded in the same cycle by a returning word or by the skid.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state           <= FETCH;
            fetch_pc        <= RESET_PC;
            discard_addr    <= RESET_PC;
            out_valid       <= 1'b0;
            out_instruction <= '0;
            out_pc          <= '0;
            has_flushed     <= 1'b0;
        end else begin
            has_flushed <= redirect;

            if (redirect) begin
                fetch_pc  <= redirect_pc;
                out_valid <= 1'b0;
                case (state)
                    FETCH: begin
                        if (!data_valid) begin
                            discard_addr <= fetch_pc;
                            state        <= DISCARD;
                        end
                    end
                    DISCARD: begin
                        if (data_valid) begin
                            state <= FETCH;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end else begin
                if (slot_consumed) begin
                    out_valid <= 1'b0;
                end

                case (state)
                    FETCH: begin
                        if (data_valid) begin
                            fetch_pc <= advance_pc(fetch_pc, PC_STEP);
                            if (slot_free) begin
                                out_valid       <= 1'b1;
                                out_instruction <= data;
                                out_pc          <= fetch_pc;
                            end else begin
                                state <= STALL;
                            end
                        end
                    end
                    DISCARD: begin
                        if (data_valid) begin
                            state <= FETCH;
                        end
                    end
                    STALL: begin
                        if (!hold) begin
                            if (skid_full) begin
                                out_valid       <= 1'b1;
                                out_instruction <= skid_entry.instruction;
                                out_pc          <= skid_entry.pc;
                            end
                            state <= FETCH;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch.sv
// ---------------------------------------------------------------------------
// tb_fetch
//
// Randomised bench for the fetch stage. A small memory model answers
// requests with random latency and checks the request protocol. A reference
// model tracks, at the level of "which instructions must reach downstream and
// in what order", the program counter and a queue of accepted but not yet
// consumed instructions. A monitor compares everything the DUT presents
// against that model.
// ---------------------------------------------------------------------------
module tb_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
    } item_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        address_enable;
    logic [31:0] address;
    logic [31:0] data;
    logic        data_valid;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        hold;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [31:0] next_pc;
    logic        has_flushed;

    int vectors_applied = 0;
    int miscompares     = 0;
    int items_delivered = 0;

    // Reference model state
    item_t       expected_q[$];
    logic [31:0] model_pc      = RESET_PC;
    logic        expect_flush  = 1'b0;
    logic        request_dead  = 1'b0;
    logic        just_reset    = 1'b1;

    // Memory model state
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_wait = 0;

    always #5 clock = ~clock;

    fetch dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .address_enable  (address_enable),
        .address         (address),
        .data            (data),
        .data_valid      (data_valid),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .hold            (hold),
        .out_valid       (out_valid),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .next_pc         (next_pc),
        .has_flushed     (has_flushed)
    );

    // Contents of instruction memory: a fixed scramble of the address, so
    // every word is distinct and traceable to where it was fetched from.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // Single comparison point: counts every comparison and reports misses.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle's worth of control inputs just after the rising edge.
    task automatic applyStimulus(input logic rst_n_v, input logic hold_v,
                                 input logic redirect_v, input logic [31:0] rpc_v);
        @(posedge clock);
        #1;
        reset_n     = rst_n_v;
        hold        = hold_v;
        redirect    = redirect_v;
        redirect_pc = rpc_v;
    endtask

    // Memory model. At each falling edge it decides what the memory does in
    // the coming cycle: a request completes on data_valid after 0..2 extra
    // cycles. While a request is open the DUT must keep address_enable high
    // and the address unchanged. A fresh request must ask for the PC that
    // the reference model expects to be fetched next.
    initial begin
        data_valid = 1'b0;
        data       = '0;
        forever begin
            @(negedge clock);
            data = $urandom();
            if (!reset_n) begin
                mem_busy   = 1'b0;
                data_valid = 1'b0;
            end else begin
                if (data_valid) begin
                    data_valid = 1'b0;
                    mem_busy   = 1'b0;
                end
                if (mem_busy) begin
                    checkOutput("req_enable_held", 32'(address_enable), 32'd1);
                    checkOutput("req_addr_stable", address, mem_addr);
                end else if (address_enable) begin
                    checkOutput("req_addr", address, model_pc);
                    mem_busy = 1'b1;
                    mem_addr = address;
                    mem_wait = $urandom_range(0, 2);
                end
                if (mem_busy) begin
                    if (mem_wait == 0) begin
                        data_valid = 1'b1;
                        data       = mem_word(mem_addr);
                    end else begin
                        mem_wait--;
                    end
                end
            end
        end
    end

    // Reference model, updated at each rising edge from the bench's own
    // inputs. Every word memory returns for a live request is an accepted
    // instruction at the current model PC, which then advances by one word.
    // A redirect throws away everything not yet consumed, jumps the PC, and
    // marks a still-open request as dead so its data is ignored later.
    initial begin
        forever begin
            @(posedge clock);
            if (!reset_n) begin
                expected_q.delete();
                model_pc     = RESET_PC;
                expect_flush = 1'b0;
                request_dead = 1'b0;
                just_reset   = 1'b1;
            end else begin
                just_reset   = 1'b0;
                expect_flush = redirect;
                if (redirect) begin
                    expected_q.delete();
                    request_dead = mem_busy && !data_valid;
                    model_pc     = redirect_pc;
                end else if (data_valid) begin
                    if (!request_dead) begin
                        expected_q.push_back('{instruction: mem_word(model_pc), pc: model_pc});
                        model_pc = model_pc + 32'd4;
                    end
                    request_dead = 1'b0;
                end
            end
        end
    end

    // Monitor. At each falling edge the DUT outputs are stable and the
    // inputs for the next edge are already driven. The head of the queue is
    // what must be on the output; it is retired when downstream takes it.
    // A full queue of two means the skid is occupied, so no request.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                checkOutput("enable_in_reset", 32'(address_enable), 32'd0);
            end else begin
                if (just_reset) begin
                    checkOutput("reset_out_instruction", out_instruction, 32'd0);
                    checkOutput("reset_out_pc", out_pc, 32'd0);
                end
                checkOutput("out_valid", 32'(out_valid), 32'(expected_q.size() > 0));
                checkOutput("address_enable", 32'(address_enable), 32'(expected_q.size() < 2));
                checkOutput("next_pc", next_pc, model_pc);
                checkOutput("has_flushed", 32'(has_flushed), 32'(expect_flush));
                if (out_valid && expected_q.size() > 0) begin
                    checkOutput("out_instruction", out_instruction, expected_q[0].instruction);
                    checkOutput("out_pc", out_pc, expected_q[0].pc);
                    if (!hold) begin
                        void'(expected_q.pop_front());
                        items_delivered++;
                    end
                end
            end
        end
    end

    // Stimulus: a few directed scenarios (plain streaming, a hold burst,
    // redirects with a request open, redirect while stalled, PC wrap,
    // back-to-back redirects, reset straight after a redirect) followed by
    // a long random mix of hold, redirect and occasional reset.
    initial begin
        logic        rst_v;
        logic        hold_v;
        logic        redir_v;
        logic [31:0] rpc_v;

        reset_n     = 1'b0;
        hold        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        repeat (3)  applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        repeat (3)  applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (5)  applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0100);
        repeat (6)  applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        repeat (4)  applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        repeat (4)  applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF4);
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0200);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0300);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0400);
        repeat (4)  applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0800);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (5)  applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 4000; i++) begin
            rst_v   = ($urandom_range(0, 299) != 0);
            hold_v  = ($urandom_range(0, 99) < 40);
            redir_v = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 9) == 0)
                rpc_v = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
            else
                rpc_v = $urandom() & 32'hFFFF_FFFC;
            applyStimulus(rst_v, hold_v, redir_v, rpc_v);
        end

        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        #2;
        checkOutput("delivered_any", 32'(items_delivered > 100), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
